// File: rtl/cdb_tag_arbiter.sv
// cdb_tag_arbiter: shares the three-slot CDB tag broadcast among NUM_FU completing
// functional units. Each cycle, up to SLOTS valid requesters are granted in round-robin
// order starting at rr_ptr. Their tags are registered into the CDB packet, which is
// visible for exactly the next cycle. Branch recovery squashes both the grants and the
// packet, so stale tags cannot set ready bits after a flush.
//
// Ports:
//   clock             system clock, posedge
//   reset             synchronous, active-high
//   bp_recover_en_i   branch-mispredict recovery; squashes this cycle's arbitration
//   fu_valid_i        requester i holds a completed tag
//   fu_tag_i          destination PR of requester i, at [i*PR +: PR]
//   fu_grant_o        combinational; requester i is accepted this cycle
//   cdb_t_o           registered broadcast {t0, t1, t2} (t0 in the MSBs); unused slot = 0
//   rr_ptr_disp_o     current round-robin start index
//   stall_cnt_disp_o  saturating count of cycles that left a valid requester ungranted
module cdb_tag_arbiter #(
  parameter int unsigned NUM_FU = 8,
  parameter int unsigned PR     = 6,
  parameter int unsigned SLOTS  = 3,
  localparam int unsigned PtrW  = $clog2(NUM_FU)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bp_recover_en_i,
  input  logic [NUM_FU-1:0]     fu_valid_i,
  input  logic [NUM_FU*PR-1:0]  fu_tag_i,
  output logic [NUM_FU-1:0]     fu_grant_o,
  output logic [SLOTS*PR-1:0]   cdb_t_o,
  output logic [PtrW-1:0]       rr_ptr_disp_o,
  output logic [7:0]            stall_cnt_disp_o
);

  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]          stall_cnt_q, stall_cnt_d;
  logic [SLOTS*PR-1:0] cdb_t_q, cdb_t_d;
  logic [NUM_FU-1:0]   grant;
  logic [PtrW-1:0]     idx, last_idx;
  int unsigned         n_grant, n_valid, sum;

  always_comb begin
    grant       = '0;
    cdb_t_d     = '0;
    n_grant     = 0;
    n_valid     = 0;
    sum         = 0;
    idx         = rr_ptr_q;
    last_idx    = rr_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;

    // Scan from rr_ptr with wrap-around; the n-th grant fills slot n (t0 first).
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      sum = 32'(rr_ptr_q) + k;
      if (sum >= NUM_FU) begin
        sum = sum - NUM_FU;
      end
      idx = PtrW'(sum);
      if (fu_valid_i[idx]) begin
        n_valid = n_valid + 1;
        if (n_grant < SLOTS) begin
          grant[idx] = 1'b1;
          cdb_t_d[(SLOTS-1-n_grant)*PR +: PR] = fu_tag_i[idx*PR +: PR];
          n_grant  = n_grant + 1;
          last_idx = idx;
        end
      end
    end

    if (bp_recover_en_i) begin
      // Squash: no handshakes, empty packet next cycle, pointer and stall count frozen.
      grant   = '0;
      cdb_t_d = '0;
    end else begin
      if (n_grant != 0) begin
        rr_ptr_d = (last_idx == PtrW'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
      end
      if ((n_valid > n_grant) && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end

    fu_grant_o = reset ? '0 : grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      cdb_t_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      cdb_t_q     <= cdb_t_d;
    end
  end

  assign cdb_t_o          = cdb_t_q;
  assign rr_ptr_disp_o    = rr_ptr_q;
  assign stall_cnt_disp_o = stall_cnt_q;

endmodule

// File: tb/tb_cdb_tag_arbiter.sv
// Self-checking bench for cdb_tag_arbiter (NUM_FU=8, PR=6). A vector table drives one
// cycle per row. Grant, pointer and stall count are checked in the same cycle. The
// expected next-cycle CDB packet goes into a queue and is popped on the following row.
module tb_cdb_tag_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        bp_recover_en;
  logic [7:0]  fu_valid;
  logic [47:0] fu_tag;
  logic [7:0]  fu_grant;
  logic [17:0] cdb_t;
  logic [2:0]  rr_ptr_disp;
  logic [7:0]  stall_cnt_disp;

  int n_chk  = 0;
  int n_fail = 0;

  logic [17:0] sb[$];

  typedef struct {
    logic        rst;
    logic        rec;
    logic [7:0]  valid;
    logic [47:0] tags;
    logic [7:0]  grant;
    logic [17:0] cdbn;
    logic [2:0]  rr;
    logic [7:0]  st;
  } vec_t;

  vec_t vecs[$];

  cdb_tag_arbiter #(
    .NUM_FU(8),
    .PR    (6),
    .SLOTS (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bp_recover_en_i (bp_recover_en),
    .fu_valid_i      (fu_valid),
    .fu_tag_i        (fu_tag),
    .fu_grant_o      (fu_grant),
    .cdb_t_o         (cdb_t),
    .rr_ptr_disp_o   (rr_ptr_disp),
    .stall_cnt_disp_o(stall_cnt_disp)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] t8(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [17:0] c3(input int x0, input int x1, input int x2);
    return {6'(x0), 6'(x1), 6'(x2)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic rec, input logic [7:0] valid,
                              input logic [47:0] tags, input logic [7:0] grant,
                              input logic [17:0] cdbn, input logic [2:0] rr,
                              input logic [7:0] st);
    vec_t v;
    v.rst = rst; v.rec = rec; v.valid = valid; v.tags = tags;
    v.grant = grant; v.cdbn = cdbn; v.rr = rr; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int i, input vec_t v);
    reset         = v.rst;
    bp_recover_en = v.rec;
    fu_valid      = v.valid;
    fu_tag        = v.tags;
    @(negedge clock);
    chk($sformatf("grant[%0d]", i), 32'(fu_grant), 32'(v.grant));
    chk($sformatf("rr_ptr[%0d]", i), 32'(rr_ptr_disp), 32'(v.rr));
    chk($sformatf("stall[%0d]", i), 32'(stall_cnt_disp), 32'(v.st));
    if (sb.size() > 0) begin
      chk($sformatf("cdb[%0d]", i), 32'(cdb_t), 32'(sb.pop_front()));
    end
    sb.push_back(v.cdbn);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Idle after reset.
    repeat (3) vecs.push_back(mk(0, 0, 8'h00, '0, 8'h00, c3(0, 0, 0), 0, 0));
    // FU1/FU4 from rr=0.
    vecs.push_back(mk(0, 0, 8'h12, t8(0, 33, 0, 0, 34, 0, 0, 0), 8'h12, c3(33, 34, 0), 0, 0));
    // Lone FU7 returns rr to 0.
    vecs.push_back(mk(0, 0, 8'h80, t8(0, 0, 0, 0, 0, 0, 0, 1), 8'h80, c3(1, 0, 0), 5, 0));
    // All eight valid, each held until granted.
    vecs.push_back(mk(0, 0, 8'hFF, t8(40, 41, 42, 43, 44, 45, 46, 47), 8'h07,
                      c3(40, 41, 42), 0, 0));
    vecs.push_back(mk(0, 0, 8'hF8, t8(40, 41, 42, 43, 44, 45, 46, 47), 8'h38,
                      c3(43, 44, 45), 3, 1));
    vecs.push_back(mk(0, 0, 8'hC0, t8(40, 41, 42, 43, 44, 45, 46, 47), 8'hC0,
                      c3(46, 47, 0), 6, 2));
    vecs.push_back(mk(0, 0, 8'h00, '0, 8'h00, c3(0, 0, 0), 0, 2));
    // Lone FU5 moves rr to 6, then the wrap-around case.
    vecs.push_back(mk(0, 0, 8'h20, t8(0, 0, 0, 0, 0, 2, 0, 0), 8'h20, c3(2, 0, 0), 0, 2));
    vecs.push_back(mk(0, 0, 8'h87, t8(63, 36, 37, 0, 0, 0, 0, 35), 8'h83,
                      c3(35, 63, 36), 6, 2));
    vecs.push_back(mk(0, 0, 8'h04, t8(0, 0, 37, 0, 0, 0, 0, 0), 8'h04, c3(37, 0, 0), 2, 3));
    // Lone FU3 moves rr to 4 so FU0 is scanned before FU3.
    vecs.push_back(mk(0, 0, 8'h08, t8(0, 0, 0, 3, 0, 0, 0, 0), 8'h08, c3(3, 0, 0), 3, 3));
    // Recovery squashes, then the held requests go through.
    vecs.push_back(mk(0, 1, 8'h09, t8(50, 0, 0, 51, 0, 0, 0, 0), 8'h00, c3(0, 0, 0), 4, 3));
    vecs.push_back(mk(0, 0, 8'h09, t8(50, 0, 0, 51, 0, 0, 0, 0), 8'h09, c3(50, 51, 0), 4, 3));
    vecs.push_back(mk(0, 0, 8'h00, '0, 8'h00, c3(0, 0, 0), 4, 3));
    // Reset with five valid requesters and stall_cnt=3.
    vecs.push_back(mk(1, 0, 8'h1F, t8(10, 0, 12, 13, 14, 0, 0, 0), 8'h00, c3(0, 0, 0), 4, 3));
    vecs.push_back(mk(1, 0, 8'h1F, t8(10, 0, 12, 13, 14, 0, 0, 0), 8'h00, c3(0, 0, 0), 0, 0));
    // Tag 0 still takes a slot; duplicate tags both broadcast.
    vecs.push_back(mk(0, 0, 8'h1F, t8(10, 0, 12, 13, 14, 0, 0, 0), 8'h07,
                      c3(10, 0, 12), 0, 0));
    vecs.push_back(mk(0, 0, 8'h18, t8(0, 0, 0, 13, 13, 0, 0, 0), 8'h18, c3(13, 13, 0), 3, 1));
    vecs.push_back(mk(0, 0, 8'h00, '0, 8'h00, c3(0, 0, 0), 5, 1));

    // Initial reset: no grants while reset is high, then clean state.
    reset         = 1'b1;
    bp_recover_en = 1'b0;
    fu_valid      = 8'hFF;
    fu_tag        = t8(1, 2, 3, 4, 5, 6, 7, 8);
    @(negedge clock);
    chk("grant_in_reset", 32'(fu_grant), 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("reset_grant", 32'(fu_grant), 32'h0);
    chk("reset_rr", 32'(rr_ptr_disp), 32'h0);
    chk("reset_stall", 32'(stall_cnt_disp), 32'h0);
    chk("reset_cdb", 32'(cdb_t), 32'h0);
    @(posedge clock);
    #1;
    sb.push_back(18'h0);

    foreach (vecs[i]) step(i, vecs[i]);

    // Stall counter saturation under continuous full demand (stall starts at 1).
    sb.delete();
    fu_valid = 8'hFF;
    fu_tag   = t8(1, 2, 3, 4, 5, 6, 7, 8);
    repeat (253) @(posedge clock);
    #1;
    chk("stall_254", 32'(stall_cnt_disp), 32'd254);
    repeat (47) @(posedge clock);
    #1;
    chk("stall_sat", 32'(stall_cnt_disp), 32'd255);
    @(negedge clock);
    chk("grant_full_demand", 32'($countones(fu_grant)), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_tag_arbiter.md
Name: cdb_tag_arbiter

Overview:
- Shares the three-slot CDB tag broadcast (t0/t1/t2) among NUM_FU completing functional units; it sources the cdb_t_in packet consumed by map_table, the RS and the ROB.
- Grants up to three requesters per cycle in round-robin order and registers the winning tags into the CDB packet one cycle later.
- Squashes arbitration and output on branch recovery (BPRecoverEN) so no stale tags set map-table ready bits after a flush.

Parameters:
- NUM_FU, 8, number of completing functional-unit requesters (>=3, <=16).
- PR, 6, physical register tag width (`PR); tag 0 means "no broadcast".
- SLOTS, 3, CDB tag slots per cycle (fixed; t0, t1, t2).

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  synchronous, active-high.
- BPRecoverEN  in  1  branch-mispredict recovery; squashes this cycle's arbitration.
- fu_valid  in  NUM_FU  requester i has a completed tag to broadcast.
- fu_tag  in  NUM_FU x PR  destination PR of requester i.
- fu_grant  out  NUM_FU  combinational; requester i is accepted this cycle.
- cdb_t  out  CDB_T_PACKET (3 x PR)  registered broadcast {t0,t1,t2}; unused slot = 0.
- rr_ptr_disp  out  clog2(NUM_FU)  current round-robin start index (debug/visibility).
- stall_cnt_disp  out  8  saturating count of cycles in which at least one valid requester was not granted.

Behaviour:
- Reset: cdb_t = 0 (all three slots), rr_ptr = 0, stall_cnt = 0, fu_grant = 0 while reset is high.
- Handshake: a requester holds fu_valid/fu_tag stable until it samples fu_grant=1 at a posedge. The transfer completes on that edge. The requester may present a new tag on the next cycle.
- Selection: scan indices rr_ptr, rr_ptr+1, ... (mod NUM_FU). The first three valid requesters are granted.
  - The 1st granted requester maps to t0, the 2nd to t1, the 3rd to t2.
  - Slots left unfilled carry tag 0.
- Latency: a tag granted in cycle N appears on cdb_t throughout cycle N+1. cdb_t is rewritten every cycle, so each broadcast lasts exactly one cycle.
- Pointer update: if at least one grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_FU. With no grant, rr_ptr holds.
- Fairness: any continuously valid requester is granted within ceil(NUM_FU/3) cycles.
- A valid requester presenting tag 0 is still granted and consumes a slot. Tag 0 is then broadcast as an empty slot, so the requester drains without effect.
- Duplicate tags from two requesters in the same cycle are both granted and both broadcast. No merging is performed.
- Recovery: when BPRecoverEN=1 in cycle N:
  - fu_grant = 0 for all requesters in cycle N.
  - cdb_t <= 0 at the end of cycle N (all slots are zero in N+1).
  - rr_ptr holds and stall_cnt does not increment.
  - The cdb_t value registered in N-1 stays visible during N.
  - Requesters discard squashed results themselves.
- stall_cnt: increments (saturating at 255) when the number of valid requesters exceeds the number of grants and BPRecoverEN=0.
- Reset mid-operation: reset overrides BPRecoverEN and pending requests. All state returns to reset values on the next edge.
- Wrap-around: the scan wraps from NUM_FU-1 to 0, e.g. rr_ptr=6 with valid {7,0,1,2} grants 7,0,1 and sets rr_ptr=2.

Test Plan:
1. Reset, then fu_valid=0 for 3 cycles -> cdb_t={0,0,0}, fu_grant=0, rr_ptr=0, stall_cnt=0.
2. rr_ptr=0, valid FU1(tag 33) and FU4(tag 34) -> fu_grant=0b00010010; next cycle cdb_t={t0=33,t1=34,t2=0}; rr_ptr=5.
3. rr_ptr=0, all 8 FUs valid (tags 40..47), held until granted:
   - cycle 1 grants 0,1,2; cycle 2 grants 3,4,5; cycle 3 grants 6,7.
   - cdb_t sequence {40,41,42},{43,44,45},{46,47,0}.
   - stall_cnt=2.
4. rr_ptr=6, valid FU7(35), FU0(63), FU1(36), FU2(37) -> t0=35, t1=63, t2=36; rr_ptr=2; FU2 granted next cycle alone -> {37,0,0}.
5. Valid FU0(50), FU3(51) with BPRecoverEN=1 -> fu_grant=0; next cycle cdb_t={0,0,0}; rr_ptr unchanged.
   - BPRecoverEN then drops with requests still held -> both granted -> {50,51,0} one cycle later.
6. Reset asserted while 5 FUs are valid and stall_cnt=3 -> next cycle cdb_t=0, rr_ptr=0, stall_cnt=0, fu_grant=0 while reset is high.
